sw4_reader: RTL and testbench

- Input-direction CPU peripheral and counterpart to the 4-bit LED output port: samples four raw slide switches, debounces them and presents each new stable value to the CPU.
- CPU polls `state_reg` and takes the value from `out_data`. It acknowledges with a one-cycle `read_flag` pulse, the input analogue of `begin_flag`.
- Sits on the memory-mapped I/O bus next to the LED port, on the same single clock.

---
 rtl/sw4_reader_if.sv | 11 +
 rtl/sw4_reader.sv | 103 ++++++++++
 tb/tb_sw4_reader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sw4_reader_if.sv
// CPU-side bus for the 4-bit switch reader: raw switch levels in, read acknowledge in,
// captured value and status out.
interface sw4_reader_if;
  logic [3:0] sw_in;
  logic       read_flag;
  logic [7:0] out_data;
  logic [7:0] state_reg;

  modport master (output sw_in, read_flag, input out_data, state_reg);
  modport slave  (input sw_in, read_flag, output out_data, state_reg);
endinterface

// File: rtl/sw4_reader.sv
// Switch input port: 2-flop synchroniser, saturating debounce counter, and a
// ready/overrun handshake so the CPU can poll and acknowledge each new stable value.
module sw4_reader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 28
) (
  input logic        clock,
  input logic        reset,
  sw4_reader_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, READY = 1'b1} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [3:0]           sync_ff1_q, sync_ff1_d;
  logic [3:0]           sync_ff2_q, sync_ff2_d;
  logic [3:0]           cand_q, cand_d;
  logic [3:0]           deb_q, deb_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           out_q, out_d;
  logic                 ovr_q, ovr_d;
  state_e               state_q, state_d;
  logic                 change;

  // Debounce: the counter saturates at the terminal count, so an accepted value
  // raises change exactly once until a different value has been stable as long.
  always_comb begin
    sync_ff1_d = bus.sw_in;
    sync_ff2_d = sync_ff1_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    deb_d      = deb_q;
    change     = 1'b0;
    if (sync_ff2_q != cand_q) begin
      cand_d = sync_ff2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_TERM) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (cand_q != deb_q) begin
      deb_d  = cand_q;
      change = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (change) state_d = READY;
      READY:   if (bus.read_flag && !change) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Overrun is only flagged when a new value lands on an unread one; a read in
  // the same cycle consumed the old value, so nothing was lost.
  always_comb begin
    out_d = out_q;
    ovr_d = ovr_q;
    case (state_q)
      IDLE: if (change) begin
        out_d = cand_q;
        ovr_d = 1'b0;
      end
      READY: begin
        if (change) begin
          out_d = cand_q;
          ovr_d = !bus.read_flag;
        end else if (bus.read_flag) begin
          ovr_d = 1'b0;
        end
      end
      default: ovr_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_ff1_q <= '0;
      sync_ff2_q <= '0;
      cand_q     <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      sync_ff1_q <= sync_ff1_d;
      sync_ff2_q <= sync_ff2_d;
      cand_q     <= cand_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.out_data  = {4'b0000, out_q};
  assign bus.state_reg = {6'b000000, ovr_q, state_q};
endmodule

// File: tb/tb_sw4_reader.sv
// Bench for sw4_reader: directed scenarios with fixed expectations, then random
// switch/read traffic compared every cycle against a sample-history reference model.
module tb_sw4_reader;
  localparam int DC = 4;
  localparam int H  = DC + 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  sw4_reader_if bus ();

  sw4_reader #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: hist[k] is the switch value sampled k edges ago (16 = unknown).
  // A value is accepted when DC+1 consecutive samples, ending two edges back, agree.
  logic [4:0] hist [0:H-1];
  logic [3:0] m_deb, m_out;
  logic       m_rdy, m_ovr, m_ok = 1'b0;

  always @(posedge clock) begin
    logic stable, ev;
    if (reset) begin
      for (int k = 0; k < H; k++) hist[k] = 5'd16;
      for (int k = 0; k < 3; k++) hist[k] = 5'd0;
      m_deb = 0; m_out = 0; m_rdy = 0; m_ovr = 0; m_ok = 1'b1;
    end else begin
      for (int k = H - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {1'b0, bus.sw_in};
      stable = (hist[2] != 5'd16);
      for (int k = 3; k <= DC + 2; k++) if (hist[k] != hist[2]) stable = 0;
      ev = stable && (hist[2][3:0] != m_deb);
      if (ev) begin
        m_ovr = m_rdy && !bus.read_flag;
        m_rdy = 1'b1;
        m_deb = hist[2][3:0];
        m_out = hist[2][3:0];
      end else if (m_rdy && bus.read_flag) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (m_ok) begin
      chk("model_out", bus.out_data, {4'b0, m_out});
      chk("model_st",  bus.state_reg, {6'b0, m_ovr, m_rdy});
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic pulse_read();
    bus.read_flag = 1'b1;
    @(negedge clock);
    bus.read_flag = 1'b0;
  endtask

  initial begin
    bus.sw_in = 4'h0;
    bus.read_flag = 1'b0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_out", bus.out_data, 8'h00);
      chk("idle_st",  bus.state_reg, 8'h00);
    end

    // Exact acceptance latency for a clean edge
    bus.sw_in = 4'hA;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      if (k < 7) chk("lat_pre", bus.state_reg, 8'h00);
    end
    chk("lat_st",  bus.state_reg, 8'h01);
    chk("lat_out", bus.out_data, 8'h0A);
    pulse_read();
    chk("rd_st",  bus.state_reg, 8'h00);
    chk("rd_out", bus.out_data, 8'h0A);

    // Return debounced to 0, then short glitches must be rejected
    bus.sw_in = 4'h0;
    step(10);
    chk("zero_st", bus.state_reg, 8'h01);
    chk("zero_out", bus.out_data, 8'h00);
    pulse_read();
    for (int g = 0; g < 5; g++) begin
      bus.sw_in = 4'h5;
      step(3);
      bus.sw_in = 4'h0;
      for (int i = 0; i < 6; i++) begin
        step(1);
        chk("glitch_st",  bus.state_reg, 8'h00);
        chk("glitch_out", bus.out_data, 8'h00);
      end
    end

    // Overrun: second value arrives before the first is read
    bus.sw_in = 4'h3;
    step(10);
    chk("ov1_st", bus.state_reg, 8'h01);
    bus.sw_in = 4'hC;
    step(10);
    chk("ov_out", bus.out_data, 8'h0C);
    chk("ov_st",  bus.state_reg, 8'h03);
    pulse_read();
    chk("ov_rd", bus.state_reg, 8'h00);

    // Read coinciding with a new value clears overrun and stays ready
    bus.sw_in = 4'h3;
    step(10);
    bus.sw_in = 4'hC;
    step(10);
    chk("co_pre", bus.state_reg, 8'h03);
    bus.sw_in = 4'h7;
    step(6);
    pulse_read();
    chk("co_st",  bus.state_reg, 8'h01);
    chk("co_out", bus.out_data, 8'h07);
    pulse_read();

    // Reset mid-debounce, then re-acceptance of the held value
    bus.sw_in = 4'hF;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rd_db_out", bus.out_data, 8'h00);
    chk("rd_db_st",  bus.state_reg, 8'h00);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      if (k < 7) chk("rel_pre", bus.state_reg, 8'h00);
    end
    chk("rel_st",  bus.state_reg, 8'h01);
    chk("rel_out", bus.out_data, 8'h0F);
    pulse_read();

    // Reset while ready
    bus.sw_in = 4'h9;
    step(10);
    chk("rr_pre_out", bus.out_data, 8'h09);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rr_out", bus.out_data, 8'h00);
    chk("rr_st",  bus.state_reg, 8'h00);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int len;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
      bus.sw_in = 4'($urandom_range(0, 15));
      len = (i % 3 == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 12));
      for (int j = 0; j < len; j++) begin
        bus.read_flag = ($urandom_range(0, 4) == 0);
        step(1);
      end
      bus.read_flag = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
